pixel_readout: RTL and testbench
================================

Name: pixel_readout

Overview:
- Sits directly downstream of RE_control in the digi_cam pipeline.
- Consumes the NRE_1, NRE_2, ADC and Erase strobes together with the digitised column values of the 2x2 sensor.
- Assembles one 4-pixel frame per readout cycle and hands it downstream as a 4-beat valid/ready stream.
- Has one capture buffer and one output buffer; flags sequencing errors and frame overruns.

Parameters:
PIX_W, 8, bit width of one pixel sample
CNT_W, 8, width of the frame counter (wraps)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
NRE_1  input  1  row 1 read enable, active low (from RE_control)
NRE_2  input  1  row 2 read enable, active low (from RE_control)
ADC  input  1  conversion-valid strobe, sample column data this cycle when high
Erase  input  1  sensor erase in progress; aborts a partial frame
col1_data  input  PIX_W  column 1 ADC result
col2_data  input  PIX_W  column 2 ADC result
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  PIX_W  pixel value for current beat
out_idx  output  2  pixel index 0..3 (row-major: r1c1, r1c2, r2c1, r2c2)
out_last  output  1  high with out_idx==3
frame_done  output  1  one-cycle pulse when a frame is moved to the output buffer
seq_err  output  1  one-cycle pulse on an illegal ADC sample
overrun  output  1  sticky; set when a completed frame is dropped
frame_cnt  output  CNT_W  count of frames delivered to the output buffer

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; the capture FSM goes to IDLE; the output buffer is empty; out_idx is 0.
- Reset mid-operation discards any captured and buffered data, including a beat in flight.

Capture FSM (states IDLE, ROW1, FULL_PEND):
- IDLE, ADC=1, NRE_1=0, NRE_2=1: latch col1 into p0 and col2 into p1. Go to ROW1.
- IDLE, ADC=1, NRE_2=0, NRE_1=1: seq_err pulse. Stay in IDLE; nothing latched.
- ROW1, ADC=1, NRE_1=0, NRE_2=1: re-latch p0/p1 (the last sample wins). Stay in ROW1.
- ROW1, ADC=1, NRE_2=0, NRE_1=1: latch col1 into p2 and col2 into p3. The frame is complete; go to FULL_PEND.
- Any state, ADC=1 with both NRE low: seq_err pulse; the sample is ignored.
- ADC=1 with both NRE high: ignored silently.
- Erase=1 in ROW1: return to IDLE and discard p0/p1. Erase has priority over a same-cycle ADC sample.

FULL_PEND handling (evaluated in the cycle after entry):
- If the output buffer is empty, or its last beat is accepted that same cycle: copy p0..p3 into the output buffer, pulse frame_done, increment frame_cnt (wraps at 2^CNT_W), go to IDLE.
- Otherwise: set overrun (sticky until reset), drop the frame, go to IDLE.
- ADC samples arriving while in FULL_PEND are treated as if in IDLE.

Output stream:
- Latency: row-2 sample at edge N, buffer load at edge N+1; out_valid=1 with out_idx=0 from N+1.
- out_data, out_idx and out_last hold stable while out_valid=1 and out_ready=0.
- A beat transfers when out_valid and out_ready are both high; out_idx then advances.
- After the idx-3 transfer, out_valid drops unless a new frame loads in that same cycle, in which case idx=0 of the new frame follows with no bubble.

Decomposition:
- Shared package digi_cam_pkg holds:
  - the capture state encoding (IDLE, ROW1, FULL_PEND);
  - pixel index constants (PIX_R1C1=0 .. PIX_R2C2=3);
  - the default PIX_W.
- One sub-module, pixel_out_buf: a 4-entry output register with an index counter and valid/ready logic. It exposes a load/empty interface to the capture FSM.

Test Plan:
- Normal frame: ADC with NRE_1=0 (col1=0x11, col2=0x22), then ADC with NRE_2=0 (0x33, 0x44), out_ready=1 -> beats 0x11, 0x22, 0x33, 0x44 with idx 0..3; out_last only on 0x44; frame_done once; frame_cnt=1.
- Backpressure: out_ready=0 for 5 cycles after the load -> out_valid=1 and out_data=0x11 stable throughout; full sequence after release.
- Overrun: out_ready=0, two complete frames captured -> second frame dropped, overrun=1, frame_cnt=1, output still 0x11..0x44.
- Sequence errors: row-2 ADC from IDLE -> seq_err pulse, no frame; ADC with both NRE low in ROW1 -> seq_err pulse, row-1 data retained.
- Erase abort: row 1 captured, Erase=1, then a row-2 ADC -> seq_err pulse, no frame_done.
- Reset mid-stream: reset at beat idx=2 -> next cycle out_valid=0, frame_cnt=0, overrun=0; FSM in IDLE; a subsequent frame streams correctly.

Source files
------------

// File: rtl/digi_cam_pkg.sv
// Shared definitions for the digi_cam readout path: capture state encoding,
// pixel index constants and the default sample width.
package digi_cam_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE      = 2'd0,
    CAP_ROW1      = 2'd1,
    CAP_FULL_PEND = 2'd2
  } cap_state_t;

  localparam logic [1:0] PIX_R1C1 = 2'd0;
  localparam logic [1:0] PIX_R1C2 = 2'd1;
  localparam logic [1:0] PIX_R2C1 = 2'd2;
  localparam logic [1:0] PIX_R2C2 = 2'd3;

  localparam int PIX_W_DEF = 8;

endpackage

// File: rtl/pixel_out_buf.sv
// Four-entry output frame register streamed as idx 0..3 over valid/ready.
// A load replaces the contents and restarts at idx 0.
module pixel_out_buf
  import digi_cam_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [4*PIX_W-1:0] i_frame,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [PIX_W-1:0]   o_data,
  output logic [1:0]         o_idx,
  output logic               o_last,
  output logic               o_empty,
  output logic               o_last_acc
);

  logic [PIX_W-1:0] r_data [4];
  logic [1:0]       r_idx;
  logic             r_valid;
  logic             w_fire;

  assign w_fire     = r_valid & i_ready;
  assign o_last_acc = w_fire & (r_idx == PIX_R2C2);
  assign o_empty    = ~r_valid;
  assign o_valid    = r_valid;
  assign o_idx      = r_idx;
  assign o_last     = r_valid & (r_idx == PIX_R2C2);
  assign o_data     = r_valid ? r_data[r_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_idx   <= PIX_R1C1;
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else if (i_load) begin
      // load wins over the last-beat transfer so the new frame follows with no bubble
      r_valid <= 1'b1;
      r_idx   <= PIX_R1C1;
      for (int i = 0; i < 4; i++) r_data[i] <= i_frame[i*PIX_W +: PIX_W];
    end else if (w_fire) begin
      if (r_idx == PIX_R2C2) begin
        r_valid <= 1'b0;
        r_idx   <= PIX_R1C1;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/pixel_readout.sv
// Captures a 2x2 frame from the RE_control strobes and hands it to the output buffer.
// state     | meaning
// IDLE      | waiting for a row-1 sample
// ROW1      | p0/p1 held, waiting for row-2 sample (Erase aborts)
// FULL_PEND | frame complete, move to output buffer or drop as overrun
module pixel_readout
  import digi_cam_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             NRE_1,
  input  logic             NRE_2,
  input  logic             ADC,
  input  logic             Erase,
  input  logic [PIX_W-1:0] col1_data,
  input  logic [PIX_W-1:0] col2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             frame_done,
  output logic             seq_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);

  cap_state_t       r_state, w_next;
  logic [PIX_W-1:0] r_p0, r_p1, r_p2, r_p3;
  logic             r_seq_err, r_frame_done, r_overrun;
  logic [CNT_W-1:0] r_frame_cnt;

  logic w_row1, w_row2, w_both;
  logic w_lat_r1, w_lat_r2, w_seq_err, w_load, w_drop;
  logic w_buf_empty, w_last_acc;

  assign w_row1 = ADC & ~NRE_1 &  NRE_2;
  assign w_row2 = ADC &  NRE_1 & ~NRE_2;
  assign w_both = ADC & ~NRE_1 & ~NRE_2;

  always_ff @(posedge clk) begin
    if (reset) r_state <= CAP_IDLE;
    else       r_state <= w_next;
  end

  // FULL_PEND samples are handled as in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      CAP_IDLE, CAP_FULL_PEND: w_next = w_row1 ? CAP_ROW1 : CAP_IDLE;
      CAP_ROW1: begin
        if (Erase)       w_next = CAP_IDLE;
        else if (w_row2) w_next = CAP_FULL_PEND;
        else             w_next = CAP_ROW1;
      end
      default:           w_next = CAP_IDLE;
    endcase
  end

  always_comb begin
    w_lat_r1  = 1'b0;
    w_lat_r2  = 1'b0;
    w_seq_err = w_both;
    w_load    = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      CAP_IDLE: begin
        w_lat_r1 = w_row1;
        if (w_row2) w_seq_err = 1'b1;
      end
      CAP_FULL_PEND: begin
        w_lat_r1 = w_row1;
        if (w_row2) w_seq_err = 1'b1;
        w_load = w_buf_empty | w_last_acc;
        w_drop = ~(w_buf_empty | w_last_acc);
      end
      CAP_ROW1: begin
        w_lat_r1 = w_row1 & ~Erase;
        w_lat_r2 = w_row2 & ~Erase;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p0         <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_p3         <= '0;
      r_seq_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_lat_r1) begin
        r_p0 <= col1_data;
        r_p1 <= col2_data;
      end
      if (w_lat_r2) begin
        r_p2 <= col1_data;
        r_p3 <= col2_data;
      end
      r_seq_err    <= w_seq_err;
      r_frame_done <= w_load;
      if (w_drop) r_overrun <= 1'b1;
      if (w_load) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  pixel_out_buf #(.PIX_W(PIX_W)) u_out_buf (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_frame    ({r_p3, r_p2, r_p1, r_p0}),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_idx      (out_idx),
    .o_last     (out_last),
    .o_empty    (w_buf_empty),
    .o_last_acc (w_last_acc)
  );

  assign seq_err    = r_seq_err;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: directed scenarios plus a randomized run checked
// against a frame-level reference model.
module tb_pixel_readout;

  logic       clk = 1'b0;
  logic       reset, NRE_1, NRE_2, ADC, Erase, out_ready;
  logic [7:0] col1_data, col2_data;
  logic       out_valid, out_last, frame_done, seq_err, overrun;
  logic [7:0] out_data, frame_cnt;
  logic [1:0] out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pixel_readout #(.PIX_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .NRE_1(NRE_1), .NRE_2(NRE_2), .ADC(ADC), .Erase(Erase),
    .col1_data(col1_data), .col2_data(col2_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .frame_done(frame_done),
    .seq_err(seq_err), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  // inputs change on the falling edge, outputs are inspected there as well
  task automatic drive(input logic adc, input logic n1, input logic n2, input logic er,
                       input logic [7:0] c1, input logic [7:0] c2);
    ADC = adc; NRE_1 = n1; NRE_2 = n2; Erase = er; col1_data = c1; col2_data = c2;
    @(negedge clk);
  endtask

  task automatic idle_cyc();   drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00); endtask
  task automatic row1(input logic [7:0] c1, input logic [7:0] c2); drive(1'b1, 1'b0, 1'b1, 1'b0, c1, c2); endtask
  task automatic row2(input logic [7:0] c1, input logic [7:0] c2); drive(1'b1, 1'b1, 1'b0, 1'b0, c1, c2); endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cyc();
    idle_cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    row1(8'h12, 8'h34);
    row2(8'h56, 8'h78);
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 2'd0 || out_last !== 1'b0 ||
        frame_done !== 1'b0 || seq_err !== 1'b0 || overrun !== 1'b0 || frame_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b data=%h idx=%0d last=%b done=%b serr=%b ovr=%b cnt=%0d, required all zero",
               out_valid, out_data, out_idx, out_last, frame_done, seq_err, overrun, frame_cnt);
    end
  endtask

  task automatic test_normal();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    out_ready = 1'b1;
    row1(8'h11, 8'h22);
    row2(8'h33, 8'h44);
    idle_cyc();
    n_checks++;
    if (frame_done !== 1'b1 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL normal_load: done=%b cnt=%0d, required done=1 cnt=1", frame_done, frame_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(i) || out_data !== exp[i] || out_last !== logic'(i == 3)) begin
        n_fail++;
        $display("FAIL normal_beat%0d: valid=%b idx=%0d data=%h last=%b, required 1 %0d %h %b",
                 i, out_valid, out_idx, out_data, out_last, i, exp[i], i == 3);
      end
      idle_cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL normal_after: valid=%b done=%b cnt=%0d, required 0 0 1", out_valid, frame_done, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    out_ready = 1'b0;
    row1(8'h11, 8'h22);
    row2(8'h33, 8'h44);
    idle_cyc();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_idx !== 2'd0 || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h idx=%0d, required 1 11 0", i, out_valid, out_data, out_idx);
      end
      idle_cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(i) || out_data !== exp[i] || out_last !== logic'(i == 3)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: valid=%b idx=%0d data=%h last=%b, required 1 %0d %h", i, out_valid, out_idx, out_data, out_last, i, exp[i]);
      end
      idle_cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    out_ready = 1'b0;
    row1(8'h11, 8'h22);
    row2(8'h33, 8'h44);
    idle_cyc();
    row1(8'h55, 8'h66);
    row2(8'h77, 8'h88);
    idle_cyc();
    n_checks++;
    if (overrun !== 1'b1 || frame_cnt !== 8'd1 || frame_done !== 1'b0 || out_data !== 8'h11 || out_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL overrun_drop: ovr=%b cnt=%0d done=%b data=%h idx=%0d, required 1 1 0 11 0",
               overrun, frame_cnt, frame_done, out_data, out_idx);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(i) || out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL overrun_beat%0d: valid=%b idx=%0d data=%h, required 1 %0d %h", i, out_valid, out_idx, out_data, i, exp[i]);
      end
      idle_cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL overrun_sticky: valid=%b ovr=%b cnt=%0d, required 0 1 1", out_valid, overrun, frame_cnt);
    end
  endtask

  task automatic test_seq_err();
    logic [7:0] exp [4];
    exp = '{8'hAA, 8'hBB, 8'hEE, 8'hFF};
    do_reset();
    out_ready = 1'b1;
    row2(8'h01, 8'h02);
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_row2_idle: seq_err=%b, required 1", seq_err);
    end
    idle_cyc();
    idle_cyc();
    n_checks++;
    if (seq_err !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL seq_no_frame: serr=%b valid=%b cnt=%0d, required 0 0 0", seq_err, out_valid, frame_cnt);
    end
    row1(8'hAA, 8'hBB);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hCC, 8'hDD);
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_both_low: seq_err=%b, required 1", seq_err);
    end
    row2(8'hEE, 8'hFF);
    idle_cyc();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(i) || out_data !== exp[i]) begin
        n_fail++;
        $display("FAIL seq_beat%0d: valid=%b idx=%0d data=%h, required 1 %0d %h", i, out_valid, out_idx, out_data, i, exp[i]);
      end
      idle_cyc();
    end
  endtask

  task automatic test_erase();
    do_reset();
    out_ready = 1'b1;
    row1(8'h11, 8'h22);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    row2(8'h33, 8'h44);
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL erase_seq: seq_err=%b, required 1", seq_err);
    end
    idle_cyc();
    idle_cyc();
    n_checks++;
    if (frame_done !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL erase_no_frame: done=%b valid=%b cnt=%0d, required 0 0 0", frame_done, out_valid, frame_cnt);
    end
    row1(8'h11, 8'h22);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h44);
    idle_cyc();
    idle_cyc();
    n_checks++;
    if (frame_done !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL erase_priority: done=%b valid=%b cnt=%0d, required 0 0 0", frame_done, out_valid, frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4];
    exp = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    do_reset();
    out_ready = 1'b0;
    row1(8'h11, 8'h22);
    row2(8'h33, 8'h44);
    idle_cyc();
    row1(8'h55, 8'h66);
    row2(8'h77, 8'h88);
    idle_cyc();
    out_ready = 1'b1;
    idle_cyc();
    idle_cyc();
    n_checks++;
    if (out_idx !== 2'd2 || out_data !== 8'h33 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: idx=%0d data=%h ovr=%b, required 2 33 1", out_idx, out_data, overrun);
    end
    reset = 1'b1;
    idle_cyc();
    n_checks++;
    if (out_valid !== 1'b0 || frame_cnt !== 8'd0 || overrun !== 1'b0 || out_idx !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: valid=%b cnt=%0d ovr=%b idx=%0d done=%b, required all 0",
               out_valid, frame_cnt, overrun, out_idx, frame_done);
    end
    reset = 1'b0;
    row1(8'h5A, 8'h6B);
    row2(8'h7C, 8'h8D);
    idle_cyc();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'(i) || out_data !== exp[i] || frame_cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d: valid=%b idx=%0d data=%h cnt=%0d, required 1 %0d %h 1",
                 i, out_valid, out_idx, out_data, frame_cnt, i, exp[i]);
      end
      idle_cyc();
    end
  endtask

  // Reference: a pending frame moves only when the stream is (or just became) empty.
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] mp [4];
    logic [7:0] snap [4];
    logic [7:0] m_cnt, c1, c2;
    bit have_r1, pend, new_pend, m_ovr, e_seq, e_done;
    bit a, n1, n2, er, rd, both, r1, r2;
    do_reset();
    q.delete();
    mp = '{8'h00, 8'h00, 8'h00, 8'h00};
    have_r1 = 0; pend = 0; m_ovr = 0; e_seq = 0; e_done = 0; m_cnt = 8'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_checks++;
      if (out_valid !== (q.size() != 0)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_valid c%0d: valid=%b, required %b", cyc, out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (out_data !== q[0] || out_idx !== 2'(4 - q.size()) || out_last !== logic'(q.size() == 1)) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL rand_beat c%0d: data=%h idx=%0d last=%b, required %h %0d %b",
                                    cyc, out_data, out_idx, out_last, q[0], 4 - q.size(), q.size() == 1);
        end
      end
      n_checks++;
      if (frame_done !== e_done || seq_err !== e_seq || overrun !== m_ovr || frame_cnt !== m_cnt) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rand_flags c%0d: done=%b serr=%b ovr=%b cnt=%0d, required %b %b %b %0d",
                                  cyc, frame_done, seq_err, overrun, frame_cnt, e_done, e_seq, m_ovr, m_cnt);
      end
      a  = ($urandom_range(0, 1) == 1);
      n1 = ($urandom_range(0, 1) == 1);
      n2 = ($urandom_range(0, 1) == 1);
      er = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 9) < 6);
      c1 = 8'($urandom);
      c2 = 8'($urandom);
      out_ready = rd;
      ADC = a; NRE_1 = n1; NRE_2 = n2; Erase = er; col1_data = c1; col2_data = c2;

      snap = mp;
      e_done = 0; e_seq = 0; new_pend = 0;
      if (q.size() != 0 && rd) void'(q.pop_front());
      if (pend) begin
        if (q.size() == 0) begin
          for (int k = 0; k < 4; k++) q.push_back(snap[k]);
          e_done = 1;
          m_cnt  = m_cnt + 8'd1;
        end else begin
          m_ovr = 1;
        end
      end
      both = a && !n1 && !n2;
      r1   = a && !n1 && n2;
      r2   = a && n1 && !n2;
      if (both) e_seq = 1;
      if (have_r1 && er) begin
        have_r1 = 0;
      end else if (r1) begin
        mp[0] = c1; mp[1] = c2; have_r1 = 1;
      end else if (r2) begin
        if (have_r1) begin
          mp[2] = c1; mp[3] = c2; have_r1 = 0; new_pend = 1;
        end else begin
          e_seq = 1;
        end
      end
      pend = new_pend;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1; Erase = 1'b0;
    col1_data = 8'h00; col2_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_normal();
    test_backpressure();
    test_overrun();
    test_seq_err();
    test_erase();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
